phase_row_tx: RTL and testbench
===============================

Name: phase_row_tx

Overview:
- Transmit side of the phase-row AXI4-Stream link consumed by match_phase.
- On a start pulse, reads one stored row of unwrapped phase samples from a simple-dual-port row RAM (fixed read latency).
- Emits the row as one AXI4-Stream packet of BEAT_SIZE samples per beat, with tlast on the final beat, under full tready backpressure.
- Sits between the row buffer filled by the capture path and the phase matcher.

Parameters:
- ROW_SIZE, 1280: samples per row; must be a multiple of BEAT_SIZE.
- BEAT_SIZE, 8: samples per AXI beat.
- DATA_WIDTH, 16: bits per sample, unsigned fixed point 8.8.
- READ_LATENCY, 2: cycles from ram_rd_en high to valid ram_rd_data; range 1..4.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to transmit one row.
- phase_offset  in  DATA_WIDTH  per-row additive offset; used only with PHASE_OFFSET_EN.
- busy  out  1  high from start acceptance until the last beat handshake.
- done  out  1  one-cycle pulse after the last beat handshake.
- ram_rd_en  out  1  row RAM read enable.
- ram_rd_addr  out  ADDR_WIDTH  beat index, 0..ROW_BEATS-1.
- ram_rd_data  in  BEAT_WIDTH  beat read from RAM; element j occupies bits [j*DATA_WIDTH +: DATA_WIDTH].
- m_axis_tdata  out  BEAT_WIDTH  output beat, same element packing.
- m_axis_tvalid  out  1  AXI4-Stream valid.
- m_axis_tready  in  1  AXI4-Stream ready.
- m_axis_tlast  out  1  marks the last beat of the row.

Behaviour:
- Derived constants: ROW_BEATS = ROW_SIZE/BEAT_SIZE (160), ADDR_WIDTH = clog2(ROW_BEATS) (8), FIFO_DEPTH = READ_LATENCY+2.
- Reset: asynchronous, active-high. Clears busy, done, ram_rd_en, m_axis_tvalid, m_axis_tlast, the address and credit counters, and the FIFO. State returns to IDLE.
- Reset mid-row: the packet is truncated without tlast. RAM data returning after reset is discarded. The next start restarts the row at address 0.
- State machine:
  - IDLE: start=1 -> STREAM; address clears to 0; phase_offset is latched; busy rises on the next edge. start is ignored whenever busy=1.
  - STREAM: ram_rd_en = 1 when (outstanding reads + FIFO occupancy) < FIFO_DEPTH. The address increments on each issued read. After address ROW_BEATS-1 is issued -> DRAIN.
  - DRAIN: no reads are issued. On the handshake of the tlast beat -> IDLE, busy falls and done pulses for one cycle.
- Read pipeline: a READ_LATENCY-deep valid shift register tags returning data, which is written into the output FIFO. The credit rule guarantees the FIFO never overflows and no read is ever dropped.
- Output: m_axis_tvalid = FIFO not empty. A beat pops on tvalid & tready. tdata and tlast are stable while tvalid=1 and tready=0.
- tlast is carried in the FIFO alongside the data; it is set only for address ROW_BEATS-1.
- Latency and throughput:
  - First tvalid appears exactly READ_LATENCY+2 cycles after the edge that samples start.
  - With tready held high, all ROW_BEATS beats are emitted on consecutive cycles with no bubbles.
- Simultaneous start and done: a start in the same cycle as done is accepted, since the state is already IDLE in that cycle.

Optional Feature:
- Macro: PHASE_OFFSET_EN.
- Defined: each sample is written into the FIFO as (ram sample + latched phase_offset) mod 2^DATA_WIDTH, wrap-around with no saturation. The adder sits on the FIFO write path and adds no latency.
- Undefined: data passes through unchanged and phase_offset is unconnected internally.

Decomposition:
- Package phase_tx_pkg holds:
  - the BEAT_WIDTH, ROW_BEATS, ADDR_WIDTH and FIFO_DEPTH constant functions;
  - the beat typedef (packed array of BEAT_SIZE × DATA_WIDTH);
  - the state enum {IDLE, STREAM, DRAIN}.
- Sub-module phase_tx_fifo: a synchronous first-word-fall-through FIFO that is (BEAT_WIDTH+1) bits wide and FIFO_DEPTH deep, with full, empty and occupancy outputs.

Test Plan:
- Basic row: RAM beat i element j = 4*(i*8+j); start with tready=1. Required response:
  - exactly 160 beats on consecutive cycles;
  - beat 0 = {28,24,…,0}; beat 159 element 7 = 0x13FC;
  - tlast only on beat 159;
  - done pulses one cycle after the final handshake.
- Backpressure:
  - tready toggles 1/0 every cycle: 160 beats arrive in order with none dropped or duplicated.
  - tready held 0 for 20 cycles mid-row: at most FIFO_DEPTH=4 reads are issued, and tdata/tlast hold stable.
- Start while busy: a second start pulse at beat 50 is ignored; exactly one packet is produced and busy stays high throughout.
- Reset mid-row: areset asserted at beat 80 clears all outputs immediately. After release, a new start yields a full 160-beat packet beginning with element 0 = 0.
- PHASE_OFFSET_EN:
  - phase_offset=0x0020 on the basic row: beat 0 element 0 = 0x0020 and element 7 = 0x003C.
  - RAM sample 0xFFF0 with offset 0x0020 outputs 0x0010 (wrap).
- Back-to-back: start asserted in the same cycle as done yields two contiguous packets with a gap of at most READ_LATENCY+2 cycles between them.

Source files
------------

// File: rtl/phase_tx_pkg.sv
// Shared constants, beat type and FSM state for the phase-row transmitter.
package phase_tx_pkg;

    localparam int BEAT_SIZE_DEF  = 8;
    localparam int DATA_WIDTH_DEF = 16;

    typedef logic [BEAT_SIZE_DEF-1:0][DATA_WIDTH_DEF-1:0] beat_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    function automatic int beat_width(input int bs, input int dw);
        return bs * dw;
    endfunction

    function automatic int row_beats(input int rs, input int bs);
        return rs / bs;
    endfunction

    function automatic int addr_width(input int rb);
        return (rb > 1) ? $clog2(rb) : 1;
    endfunction

    function automatic int fifo_depth(input int lat);
        return lat + 2;
    endfunction

endpackage

// File: rtl/phase_tx_fifo.sv
// First-word-fall-through FIFO for beats plus tlast, with occupancy count.
module phase_tx_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= nxt(wr_ptr);
            if (pop)
                rd_ptr <= nxt(rd_ptr);
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/phase_row_tx.sv
// Streams one stored phase row from the row RAM as an AXI4-Stream packet.
// Optional PHASE_OFFSET_EN adds a per-row offset to every sample.
module phase_row_tx
    import phase_tx_pkg::*;
#(
    parameter int ROW_SIZE     = 1280,
    parameter int BEAT_SIZE    = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 2,
    localparam int BEAT_WIDTH  = beat_width(BEAT_SIZE, DATA_WIDTH),
    localparam int ROW_BEATS   = row_beats(ROW_SIZE, BEAT_SIZE),
    localparam int ADDR_WIDTH  = addr_width(ROW_BEATS)
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] phase_offset,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [BEAT_WIDTH-1:0] ram_rd_data,
    output logic [BEAT_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);

    localparam int FIFO_DEPTH = fifo_depth(READ_LATENCY);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int UW = $clog2(2 * FIFO_DEPTH + 2);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ROW_BEATS - 1);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [READ_LATENCY-1:0] vld_pipe;
    logic [READ_LATENCY-1:0] last_pipe;
    logic [BEAT_WIDTH-1:0]   wr_beat;
    logic [BEAT_WIDTH:0]     fifo_dout;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CW-1:0]           fifo_count;
    logic                    pop;
    logic [UW-1:0]           inflight;
    logic [UW-1:0]           used;
    logic                    credit;
    logic                    unused_full;

    assign unused_full = fifo_full;

`ifdef PHASE_OFFSET_EN
    logic [DATA_WIDTH-1:0] offset_q;
`else
    logic unused_offset;
    assign unused_offset = ^phase_offset;
`endif

    assign pop = m_axis_tvalid && m_axis_tready;

    // Slots already claimed after this edge: reads in flight plus FIFO entries.
    always_comb begin
        inflight = UW'(ram_rd_en);
        for (int k = 0; k < READ_LATENCY; k++)
            inflight = inflight + UW'(vld_pipe[k]);
    end

    assign used   = inflight + UW'(fifo_count) - UW'(pop);
    assign credit = (used < UW'(FIFO_DEPTH));

    always_comb begin
        wr_beat = ram_rd_data;
`ifdef PHASE_OFFSET_EN
        for (int j = 0; j < BEAT_SIZE; j++)
            wr_beat[j*DATA_WIDTH +: DATA_WIDTH] =
                ram_rd_data[j*DATA_WIDTH +: DATA_WIDTH] + offset_q;
`endif
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state       <= IDLE;
            addr        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ram_rd_en   <= 1'b0;
            ram_rd_addr <= '0;
            vld_pipe    <= '0;
            last_pipe   <= '0;
`ifdef PHASE_OFFSET_EN
            offset_q    <= '0;
`endif
        end else begin
            done      <= 1'b0;
            vld_pipe  <= (vld_pipe << 1) | READ_LATENCY'(ram_rd_en);
            last_pipe <= (last_pipe << 1)
                       | READ_LATENCY'(ram_rd_en && ram_rd_addr == LAST_ADDR);
            unique case (state)
                IDLE: begin
                    ram_rd_en <= 1'b0;
                    if (start) begin
                        state <= STREAM;
                        addr  <= '0;
                        busy  <= 1'b1;
`ifdef PHASE_OFFSET_EN
                        offset_q <= phase_offset;
`endif
                    end
                end
                STREAM: begin
                    ram_rd_en <= credit;
                    if (credit) begin
                        ram_rd_addr <= addr;
                        addr        <= addr + 1'b1;
                        if (addr == LAST_ADDR)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    ram_rd_en <= 1'b0;
                    if (pop && m_axis_tlast) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    phase_tx_fifo #(
        .WIDTH (BEAT_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (aclk),
        .rst     (areset),
        .wr_en   (vld_pipe[READ_LATENCY-1]),
        .wr_data ({last_pipe[READ_LATENCY-1], wr_beat}),
        .rd_en   (pop),
        .rd_data (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_dout[BEAT_WIDTH-1:0];
    assign m_axis_tlast  = !fifo_empty && fifo_dout[BEAT_WIDTH];

endmodule

// File: tb/tb_phase_row_tx.sv
// Scoreboard bench for phase_row_tx: directed rows, backpressure, reset, restart.
module tb_phase_row_tx;
    import phase_tx_pkg::*;

    localparam int LAT = 2;
    localparam int ROW_BEATS = 160;
    localparam int AW = 8;
    localparam int BW = 128;
    localparam int FD = LAT + 2;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   phase_offset = 16'h0020;
    logic          busy;
    logic          done;
    logic          ram_rd_en;
    logic [AW-1:0] ram_rd_addr;
    logic [BW-1:0] ram_rd_data;
    logic [BW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tlast;

    phase_row_tx #(
        .ROW_SIZE     (1280),
        .BEAT_SIZE    (8),
        .DATA_WIDTH   (16),
        .READ_LATENCY (LAT)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .start         (start),
        .phase_offset  (phase_offset),
        .busy          (busy),
        .done          (done),
        .ram_rd_en     (ram_rd_en),
        .ram_rd_addr   (ram_rd_addr),
        .ram_rd_data   (ram_rd_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    always #5 aclk = ~aclk;

    // Row RAM model with fixed read latency
    beat_t ram_mem [ROW_BEATS];
    beat_t rpipe [LAT];

    always @(posedge aclk) begin
        rpipe[0] <= ram_rd_en ? ram_mem[ram_rd_addr] : '0;
        for (int k = 1; k < LAT; k++)
            rpipe[k] <= rpipe[k-1];
    end
    assign ram_rd_data = rpipe[LAT-1];

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    logic [BW:0]   exp_q [$];
    int            vectors = 0;
    int            miscompares = 0;
    int            beats;
    int            first_valid_cyc, first_hs_cyc, last_hs_cyc;
    int            second_hs_cyc, done_cyc, done_cnt, start_cyc;
    bit            seen_valid, done_seen;
    logic [BW-1:0] cap [ROW_BEATS];

    task automatic check(input string name, input logic [BW-1:0] act,
                         input logic [BW-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake
    initial begin
        logic [BW:0] e;
        forever begin
            @(negedge aclk);
            if (m_axis_tvalid && !seen_valid) begin
                seen_valid = 1'b1;
                first_valid_cyc = cyc;
            end
            if (done) begin
                if (done_cnt == 0)
                    done_cyc = cyc;
                done_cnt++;
                done_seen = 1'b1;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", m_axis_tdata, e[BW-1:0]);
                    check("beat_last", BW'(m_axis_tlast), BW'(e[BW]));
                end
                if (beats == 0) first_hs_cyc = cyc;
                if (beats == ROW_BEATS - 1) last_hs_cyc = cyc;
                if (beats == ROW_BEATS) second_hs_cyc = cyc;
                if (beats < ROW_BEATS) cap[beats] = m_axis_tdata;
                beats++;
            end
        end
    end

    function automatic logic [BW-1:0] exp_beat(input int i);
        beat_t b;
        b = ram_mem[i];
`ifdef PHASE_OFFSET_EN
        for (int j = 0; j < 8; j++)
            b[j] = b[j] + phase_offset;
`endif
        return b;
    endfunction

    task automatic push_row();
        for (int i = 0; i < ROW_BEATS; i++)
            exp_q.push_back({(i == ROW_BEATS - 1), exp_beat(i)});
    endtask

    task automatic fill_ram();
        for (int i = 0; i < ROW_BEATS; i++)
            for (int j = 0; j < 8; j++)
                ram_mem[i][j] = 16'(4 * (i * 8 + j));
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_stats();
        beats = 0;
        seen_valid = 1'b0;
        done_seen = 1'b0;
        done_cnt = 0;
    endtask

    // mode 0 ready high, 1 toggle, 2 stall, 3 restart, 4 reset, 5 back-to-back
    task automatic run_pkt(input int mode);
        int t;
        int hold_st, hold_cnt, hold_rd, unstable, busy_gaps;
        bit extra;
        logic [BW-1:0] hd;
        logic hl;
        t = 0; hold_st = 0; hold_cnt = 0; hold_rd = 0;
        unstable = 0; busy_gaps = 0; extra = 1'b0;
        clear_stats();
        push_row();
        if (mode == 5) push_row();
        m_axis_tready = 1'b1;
        start = 1'b1;
        start_cyc = cyc;
        step();
        start = 1'b0;
        while (!(done_seen && (mode != 5 || done_cnt >= 2)) && t < 3000) begin
            if (!busy && !done) busy_gaps++;
            start = 1'b0;
            case (mode)
                1: m_axis_tready = ~m_axis_tready;
                2: begin
                    if (hold_st == 0 && beats >= 60) begin
                        m_axis_tready = 1'b0;
                        hd = m_axis_tdata;
                        hl = m_axis_tlast;
                        hold_st = 1;
                    end
                    if (hold_st == 1) begin
                        if (m_axis_tdata !== hd || m_axis_tlast !== hl || !m_axis_tvalid)
                            unstable++;
                        if (ram_rd_en) hold_rd++;
                        hold_cnt++;
                        if (hold_cnt == 20) begin
                            m_axis_tready = 1'b1;
                            hold_st = 2;
                        end
                    end
                end
                3: if (!extra && beats >= 50) begin
                    start = 1'b1;
                    extra = 1'b1;
                end
                4: if (beats >= 80) begin
                    areset = 1'b1;
                    #1;
                    check("rst_tvalid", BW'(m_axis_tvalid), 0);
                    check("rst_tlast", BW'(m_axis_tlast), 0);
                    check("rst_busy", BW'(busy), 0);
                    check("rst_rd_en", BW'(ram_rd_en), 0);
                    check("rst_done", BW'(done), 0);
                    exp_q.delete();
                    start = 1'b0;
                    step();
                    step();
                    areset = 1'b0;
                    step();
                    return;
                end
                5: if (done && !extra) begin
                    start = 1'b1;
                    extra = 1'b1;
                end
                default: ;
            endcase
            step();
            t++;
        end
        start = 1'b0;
        m_axis_tready = 1'b1;
        check("timeout", BW'(t < 3000), 1);
        repeat (5) step();
        check("beat_count", BW'(beats), BW'((mode == 5) ? 2 * ROW_BEATS : ROW_BEATS));
        check("queue_empty", BW'(exp_q.size()), 0);
        check("busy_gap", BW'(busy_gaps), 0);
        check("first_valid_lat", BW'(first_valid_cyc - (start_cyc + 1)), BW'(LAT + 2));
        check("done_after_last", BW'(done_cyc - last_hs_cyc), 1);
        check("done_pulses", BW'(done_cnt), BW'((mode == 5) ? 2 : 1));
        if (mode == 0)
            check("no_bubbles", BW'(last_hs_cyc - first_hs_cyc), BW'(ROW_BEATS - 1));
        if (mode == 2) begin
            check("stall_reads", BW'(hold_rd <= FD), 1);
            check("stall_stable", BW'(unstable), 0);
        end
        if (mode == 3) begin
            repeat (20) step();
            check("single_pkt_busy", BW'(busy), 0);
            check("single_pkt_valid", BW'(m_axis_tvalid), 0);
        end
        if (mode == 5)
            check("b2b_gap", BW'(second_hs_cyc - done_cyc - 1 <= LAT + 2), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_ram();
        clear_stats();
        repeat (3) step();
        check("reset_busy", BW'(busy), 0);
        check("reset_done", BW'(done), 0);
        check("reset_rd_en", BW'(ram_rd_en), 0);
        check("reset_tvalid", BW'(m_axis_tvalid), 0);
        check("reset_tlast", BW'(m_axis_tlast), 0);
        areset = 1'b0;
        repeat (2) step();

        run_pkt(0);
`ifdef PHASE_OFFSET_EN
        check("beat0_const", cap[0], 128'h003C_0038_0034_0030_002C_0028_0024_0020);
        check("beat159_e7", BW'(cap[ROW_BEATS-1][127:112]), BW'(16'h141C));
`else
        check("beat0_const", cap[0], 128'h001C_0018_0014_0010_000C_0008_0004_0000);
        check("beat159_e7", BW'(cap[ROW_BEATS-1][127:112]), BW'(16'h13FC));
`endif

        run_pkt(1);
        run_pkt(2);
        run_pkt(3);

        run_pkt(4);
        phase_offset = 16'h0000;
        run_pkt(0);
        check("post_reset_e0", BW'(cap[0][15:0]), 0);
        phase_offset = 16'h0020;

`ifdef PHASE_OFFSET_EN
        ram_mem[0][0] = 16'hFFF0;
        run_pkt(0);
        check("offset_wrap", BW'(cap[0][15:0]), BW'(16'h0010));
        fill_ram();
`endif

        run_pkt(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
